// File: rtl/toonify_pkg.sv
// toonify_pkg: shared pixel and 3x3 window types for the toonify pipeline
package toonify_pkg;
  localparam int DSIZE = 8;
  localparam int WIN_N = 9;
  typedef logic [WIN_N*DSIZE-1:0] window_t;
endpackage

// File: rtl/window3x3_gen_line_delay.sv
// line_delay: enable-gated delay of exactly WIDTH accepted samples (circular buffer)
module line_delay #(
  parameter int WIDTH = 320,
  parameter int DSIZE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [DSIZE-1:0] i_din,
  output logic [DSIZE-1:0] o_dout
);
  localparam int AW = $clog2(WIDTH);
  logic [DSIZE-1:0] mem [WIDTH];
  logic [AW-1:0]    ptr;
  assign o_dout = mem[ptr];
  // storage is never reset; readers mask stale content by row/col gating
  always_ff @(posedge i_clk)
    if (i_en) mem[ptr] <= i_din;
  // the slot just read is the oldest one, so it is overwritten next
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ptr <= '0;
    else if (i_en) ptr <= (ptr == AW'(WIDTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/window3x3_gen.sv
// window3x3_gen: raster-stream 3x3 window generator; define WIN_OUT_REG_EN for an extra output stage
module window3x3_gen #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DSIZE  = toonify_pkg::DSIZE
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_valid,
  input  logic                                i_sof,
  input  logic [DSIZE-1:0]                    i_pixel,
  output logic                                o_valid,
  output logic [toonify_pkg::WIN_N*DSIZE-1:0] o_window,
  output logic                                o_frame_done
);
  import toonify_pkg::*;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  logic [CW-1:0] col, ec;
  logic [RW-1:0] row, er;
  logic last_c, last_r, win_ok;
  logic [DSIZE-1:0] d1, d2, t1, t2, m1, m2, b1, b2;
  logic [WIN_N*DSIZE-1:0] nw, w1;
  logic v1, fd1;
  assign ec = i_sof ? '0 : col;
  assign er = i_sof ? '0 : row;
  assign last_c = ec == CW'(WIDTH - 1);
  assign last_r = er == RW'(HEIGHT - 1);
  assign win_ok = er >= RW'(2) && ec >= CW'(2);
  assign nw = {t1, t2, d2, m1, m2, d1, b1, b2, i_pixel};
  line_delay #(.WIDTH(WIDTH), .DSIZE(DSIZE)) u_ld1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_valid), .i_din(i_pixel), .o_dout(d1)
  );
  line_delay #(.WIDTH(WIDTH), .DSIZE(DSIZE)) u_ld2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_valid), .i_din(d1), .o_dout(d2)
  );
  // position tracking, column shift registers and gated window capture
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      col <= '0;
      row <= '0;
      {t1, t2, m1, m2, b1, b2} <= '0;
      w1  <= '0;
      v1  <= 1'b0;
      fd1 <= 1'b0;
    end else begin
      v1  <= i_valid & win_ok;
      fd1 <= i_valid & last_c & last_r;
      if (i_valid) begin
        col <= last_c ? '0 : ec + 1'b1;
        row <= last_c ? (last_r ? '0 : er + 1'b1) : er;
        {t1, t2} <= {t2, d2};
        {m1, m2} <= {m2, d1};
        {b1, b2} <= {b2, i_pixel};
        if (win_ok) w1 <= nw;
      end
    end
`ifdef WIN_OUT_REG_EN
  logic v2, fd2;
  logic [WIN_N*DSIZE-1:0] w2;
  // extra output register stage
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      v2  <= 1'b0;
      fd2 <= 1'b0;
      w2  <= '0;
    end else begin
      v2  <= v1;
      fd2 <= fd1;
      w2  <= w1;
    end
  assign o_valid      = v2;
  assign o_frame_done = fd2;
  assign o_window     = w2;
`else
  assign o_valid      = v1;
  assign o_frame_done = fd1;
  assign o_window     = w1;
`endif
endmodule

// File: tb/tb_window3x3_gen.sv
// tb_window3x3_gen: directed bench with a frame-image reference model for window3x3_gen
module tb_window3x3_gen;
  import toonify_pkg::*;
  localparam int W = 5;
  localparam int H = 4;
`ifdef WIN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b1, valid = 1'b0, sof = 1'b0;
  logic [7:0] pix = '0;
  logic o_valid, o_frame_done;
  window_t o_window;
  window_t got[$];
  logic [7:0] img [H][W];
  logic pv [LAT];
  logic pf [LAT];
  window_t pw [LAT];
  int mr = 0, mc = 0, cyc = 0, checks = 0, passed = 0, fd_n = 0, fd_cyc = 0, acc_cyc = 0;
  int ofs [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int b6 [6] = '{0, 1, 2, 5, 6, 7};

  window3x3_gen #(.WIDTH(W), .HEIGHT(H), .DSIZE(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sof(sof), .i_pixel(pix),
    .o_valid(o_valid), .o_window(o_window), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  function automatic window_t mkw(input int b);
    window_t w;
    for (int k = 0; k < 9; k++) w[71-8*k -: 8] = 8'(b + ofs[k]);
    return w;
  endfunction

  task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
    checks++;
    if (a !== e) $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    else passed++;
  endtask

  task automatic clr_model();
    mr = 0;
    mc = 0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pf[i] = 1'b0;
      pw[i] = '0;
    end
  endtask

  task automatic tick(input logic v, input logic s, input logic [7:0] d);
    int r, c;
    @(negedge clk);
    cyc++;
    chk("o_valid", 72'(o_valid), 72'(pv[LAT-1]));
    chk("o_frame_done", 72'(o_frame_done), 72'(pf[LAT-1]));
    if (pv[LAT-1]) chk("o_window", o_window, pw[LAT-1]);
    if (o_valid) got.push_back(o_window);
    if (o_frame_done) begin
      fd_n++;
      fd_cyc = cyc;
    end
    valid = v;
    sof = s;
    pix = d;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pf[i] = pf[i-1];
      pw[i] = pw[i-1];
    end
    pv[0] = 1'b0;
    pf[0] = 1'b0;
    pw[0] = '0;
    if (v) begin
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      img[r][c] = d;
      if (r >= 2 && c >= 2) begin
        pv[0] = 1'b1;
        pw[0] = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                 img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                 img[r][c-2],   img[r][c-1],   img[r][c]};
      end
      pf[0] = (r == H - 1 && c == W - 1);
      mc = (c == W - 1) ? 0 : c + 1;
      mr = (c == W - 1) ? ((r == H - 1) ? 0 : r + 1) : r;
    end
  endtask

  task automatic frame(input int n, input int base, input bit sof_first, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) tick(1'b0, 1'b0, 8'h00);
      tick(1'b1, sof_first && i == 0, 8'(base + i));
      acc_cyc = cyc;
    end
  endtask

  task automatic do_rst();
    @(negedge clk);
    valid = 1'b0;
    sof = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst o_valid", 72'(o_valid), 72'(0));
    chk("rst o_frame_done", 72'(o_frame_done), 72'(0));
    chk("rst o_window", o_window, 72'(0));
    repeat (2) @(negedge clk);
    clr_model();
    rst_n = 1'b1;
  endtask

  task automatic check_six(input string n);
    chk({n, " count"}, 72'(got.size()), 72'(6));
    for (int i = 0; i < 6; i++) chk({n, " window"}, got[i], mkw(b6[i]));
    chk({n, " frame_done"}, 72'(fd_n), 72'(1));
  endtask

  initial begin
    clr_model();
    do_rst();
    // continuous frame, sof on first pixel
    got.delete();
    fd_n = 0;
    frame(20, 0, 1'b1, 0);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
    chk("first window", got[0], {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
    chk("last window", got[5], {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19});
    chk("done latency", 72'(fd_cyc - acc_cyc), 72'(LAT));
    check_six("continuous");
    // same stream with random gaps
    got.delete();
    fd_n = 0;
    frame(20, 0, 1'b1, 3);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
    check_six("gapped");
    // sof at pixel 8 aborts the frame
    got.delete();
    fd_n = 0;
    frame(8, 100, 1'b1, 0);
    frame(20, 0, 1'b1, 0);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
    check_six("sof abort");
    // reset mid-frame, then a frame without sof
    frame(13, 200, 1'b1, 0);
    do_rst();
    got.delete();
    fd_n = 0;
    frame(20, 0, 1'b0, 1);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
    check_six("after reset");
    // two back-to-back frames, sof only on the first
    got.delete();
    fd_n = 0;
    frame(20, 0, 1'b1, 0);
    frame(20, 50, 1'b0, 0);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
    chk("b2b count", 72'(got.size()), 72'(12));
    chk("b2b frame_done", 72'(fd_n), 72'(2));
    chk("b2b second first", got[6], mkw(50));
    chk("b2b second last", got[11], mkw(57));
    // idle input never yields windows
    got.delete();
    repeat (10) tick(1'b0, 1'b0, 8'h00);
    chk("idle count", 72'(got.size()), 72'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/window3x3_gen.md
WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
REQ-001 SHALL have parameter: WIDTH, 320, active pixels per line (min 3).
REQ-002 SHALL have parameter: HEIGHT, 240, lines per frame (min 3).
REQ-003 SHALL have parameter: DSIZE, 8, bits per pixel.
REQ-004 SHALL have port: i_clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: i_valid  input  1  i_pixel carries a raster-order pixel this cycle.
REQ-007 SHALL have port: i_sof  input  1  start of frame, qualified by i_valid; the pixel is (row 0, col 0).
REQ-008 SHALL have port: i_pixel  input  DSIZE  grayscale pixel.
REQ-009 SHALL have port: o_valid  output  1  o_window holds a complete interior 3x3 window.
REQ-010 SHALL have port: o_window  output  9*DSIZE  window packed p0 at MSBs [9*DSIZE-1 -: DSIZE] through p8 at LSBs.
REQ-011 SHALL have port: o_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 SHALL accept a pixel only on cycles with i_valid=1; no backpressure; gaps of any length SHALL freeze all state.
REQ-013 SHALL track col (0..WIDTH-1) and row (0..HEIGHT-1) counters, advancing col per accepted pixel, wrapping col to 0 and incrementing row at WIDTH-1.
REQ-014 SHALL wrap row to 0 after the pixel (HEIGHT-1, WIDTH-1) and pulse o_frame_done the following cycle.
REQ-015 SHALL treat an accepted pixel with i_sof=1 as (0,0) regardless of counter state; the frame restarts, a pending o_frame_done is not generated.
REQ-016 SHALL keep two line delays of WIDTH pixels holding rows r-1 and r-2 at the current column.
REQ-017 SHALL, for accepted pixel (r,c), form window p0..p2 = row r-2 cols c-2..c, p3..p5 = row r-1 cols c-2..c, p6..p8 = row r cols c-2..c.
REQ-018 SHALL assert o_valid for exactly one cycle, one cycle after accepting (r,c), iff r>=2 and c>=2; yields (WIDTH-2)*(HEIGHT-2) windows per frame.
REQ-019 SHALL hold o_window at its last value when o_valid=0; content is don't-care then.
REQ-020 SHALL never produce a window mixing pixels across a line wrap or across an i_sof restart (row gating after i_sof).
REQ-021 SHALL, if i_valid is held low, never assert o_valid.

Reset
REQ-022 SHALL on i_rst_n low drive o_valid=0, o_frame_done=0, o_window=0 and clear row/col counters and the 3x3 window registers.
REQ-023 SHALL not require line-delay storage to be reset; stale content SHALL be masked by REQ-018 gating.
REQ-024 SHALL, after reset mid-frame, treat the next accepted pixel as (0,0) even without i_sof.

Configuration
REQ-025 SHALL support macro WIN_OUT_REG_EN: defined -> one extra output register stage on o_valid, o_window, o_frame_done (latency 2 cycles); undefined -> latency 1 cycle per REQ-018.
REQ-026 SHALL keep window counts, ordering and reset values identical in both configurations.

Structure
REQ-027 SHALL take DSIZE, window size constant 9, and a packed window typedef from shared package toonify_pkg, also used by the gradient stage.
REQ-028 SHALL instantiate sub-module line_delay (parameters WIDTH, DSIZE; enable-gated, WIDTH-cycle delay) twice, cascaded.

Verification
REQ-029 SHALL test WIDTH=5,HEIGHT=4, pixels 0..19 continuous with i_sof on first -> 6 windows; first window = {0,1,2,5,6,7,10,11,12}, last = {7,8,9,12,13,14,17,18,19}; o_frame_done pulse 1 cycle after pixel 19.
REQ-030 SHALL test same stream with random i_valid gaps -> identical 6 windows in order, o_valid never during gaps.
REQ-031 SHALL test i_sof asserted at pixel 8 of a frame -> no o_frame_done for aborted frame, first window of new frame appears only after new row 2 col 2 is accepted.
REQ-032 SHALL test i_rst_n pulsed mid-frame -> outputs 0 during reset, next accepted pixel treated as (0,0), no windows from stale line data.
REQ-033 SHALL test two back-to-back frames without i_sof on second -> 12 windows total, 2 o_frame_done pulses.
REQ-034 SHALL run REQ-029 with WIN_OUT_REG_EN defined -> same windows, each one cycle later.
